decomp_bit_aligner: RTL and testbench

- Bit-stream aligner and scheduler for the word-decompression path; holds compressed data in a WIDTH-bit MSB-first buffer.
- Time-shares two barrel_shifter_d2 instances in one cycle:
  - consume shifter: left-shifts the buffer by the number of bits the decoder takes.
  - append shifter: places each incoming compressed word directly after the remaining valid bits.
- Sits between the compressed-word input stream and the field decoder, which reads o_peek and returns a consumed length.

---
 rtl/decomp_align_pkg.sv | 7 +
 rtl/decomp_bit_aligner_if.sv | 27 ++
 rtl/barrel_shifter_d2.sv | 15 +
 rtl/decomp_bit_aligner.sv | 96 +++++++++
 tb/tb_decomp_bit_aligner.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/decomp_align_pkg.sv
// decomp_align_pkg: shared state encoding and default geometry for the bit aligner.
package decomp_align_pkg;
    localparam int DEF_WIDTH = 196;
    localparam int DEF_IN_W  = 32;
    localparam int DEF_OUT_W = 64;
    typedef enum logic [1:0] {ST_FILL, ST_DRAIN, ST_ERR} align_state_e;
endpackage

// File: rtl/decomp_bit_aligner_if.sv
// decomp_bit_aligner_if: compressed-word input stream plus the decoder peek/take channel.
interface decomp_bit_aligner_if
    import decomp_align_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int IN_W  = DEF_IN_W,
    parameter int OUT_W = DEF_OUT_W
);
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam int LEN_W = $clog2(OUT_W + 1);
    logic             i_in_valid;
    logic [IN_W-1:0]  i_in_word;
    logic             i_in_last;
    logic             o_in_ready;
    logic [OUT_W-1:0] o_peek;
    logic [CNT_W-1:0] o_fill;
    logic             i_take;
    logic [LEN_W-1:0] i_take_len;
    modport master (
        output i_in_valid, i_in_word, i_in_last, i_take, i_take_len,
        input  o_in_ready, o_peek, o_fill
    );
    modport slave (
        input  i_in_valid, i_in_word, i_in_last, i_take, i_take_len,
        output o_in_ready, o_peek, o_fill
    );
endinterface

// File: rtl/barrel_shifter_d2.sv
// barrel_shifter_d2: combinational logical left shifter, one mux stage per shift-amount bit.
module barrel_shifter_d2 #(
    parameter int WIDTH     = 196,
    parameter int SHIFT_BIT = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0]     i_data,
    input  logic [SHIFT_BIT-1:0] i_shamt,
    output logic [WIDTH-1:0]     o_data
);
    always_comb begin
        o_data = i_data;
        for (int k = 0; k < SHIFT_BIT; k++)
            o_data = i_shamt[k] ? o_data << (1 << k) : o_data;
    end
endmodule

// File: rtl/decomp_bit_aligner.sv
// decomp_bit_aligner: MSB-first bit buffer that realigns compressed words for the field decoder.
// DECOMP_ALIGN_STATS_EN builds saturating accepted-word / consumed-bit counters.
module decomp_bit_aligner
    import decomp_align_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int IN_W      = DEF_IN_W,
    parameter int OUT_W     = DEF_OUT_W,
    parameter int SHIFT_BIT = $clog2(WIDTH),
    parameter int CNT_W     = $clog2(WIDTH + 1),
    parameter int LEN_W     = $clog2(OUT_W + 1)
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_flush,
    decomp_bit_aligner_if.slave bus,
    output logic                o_done,
    output logic                o_err,
    output logic [31:0]         o_stat_words,
    output logic [31:0]         o_stat_bits
);
    align_state_e     state, state_nxt;
    logic [WIDTH-1:0] buf_q, buf_nxt, shifted, appended;
    logic [CNT_W-1:0] fill_q, fill_t, fill_nxt, t;
    logic             take_ok, take_bad, accept, done_q;

    assign take_ok  = bus.i_take && state != ST_ERR && CNT_W'(bus.i_take_len) <= fill_q
                      && bus.i_take_len <= LEN_W'(OUT_W);
    assign take_bad = bus.i_take && state != ST_ERR && !take_ok;
    // an illegal take freezes the buffer, so a word offered alongside it is dropped too
    assign accept   = bus.i_in_valid && bus.o_in_ready && !take_bad;
    assign t        = take_ok ? CNT_W'(bus.i_take_len) : '0;
    assign fill_t   = fill_q - t;

    barrel_shifter_d2 #(.WIDTH(WIDTH), .SHIFT_BIT(SHIFT_BIT)) u_consume (
        .i_data  (buf_q),
        .i_shamt (SHIFT_BIT'(t)),
        .o_data  (shifted)
    );

    barrel_shifter_d2 #(.WIDTH(WIDTH), .SHIFT_BIT(SHIFT_BIT)) u_append (
        .i_data  (WIDTH'(bus.i_in_word)),
        .i_shamt (SHIFT_BIT'(CNT_W'(WIDTH - IN_W) - fill_t)),
        .o_data  (appended)
    );

    assign buf_nxt  = accept ? shifted | appended : shifted;
    assign fill_nxt = accept ? fill_t + CNT_W'(IN_W) : fill_t;

    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) state <= ST_FILL;
        else          state <= state_nxt;

    always_comb begin
        state_nxt = i_flush                                        ? ST_FILL  :
                    take_bad                                       ? ST_ERR   :
                    (state == ST_FILL && accept && bus.i_in_last)  ? ST_DRAIN :
                    (state == ST_DRAIN && fill_nxt == '0)          ? ST_FILL  : state;
    end

    always_comb begin
        bus.o_in_ready = i_rst_n && state == ST_FILL && fill_q <= CNT_W'(WIDTH - IN_W);
        o_err          = state == ST_ERR;
    end

    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) begin
            buf_q  <= '0;
            fill_q <= '0;
            done_q <= 1'b0;
        end else begin
            buf_q  <= i_flush ? '0 : buf_nxt;
            fill_q <= i_flush ? '0 : fill_nxt;
            done_q <= !i_flush && state == ST_DRAIN && !take_bad && fill_nxt == '0;
        end

    assign bus.o_peek = buf_q[WIDTH-1 -: OUT_W];
    assign bus.o_fill = fill_q;
    assign o_done     = done_q;

`ifdef DECOMP_ALIGN_STATS_EN
    logic [32:0] bits_sum;
    assign bits_sum = {1'b0, o_stat_bits} + 33'(t);
    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) begin
            o_stat_words <= '0;
            o_stat_bits  <= '0;
        end else if (!i_flush) begin
            o_stat_words <= (accept && o_stat_words != '1) ? o_stat_words + 32'd1 : o_stat_words;
            o_stat_bits  <= bits_sum[32] ? '1 : bits_sum[31:0];
        end
`else
    assign o_stat_words = '0;
    assign o_stat_bits  = '0;
`endif
endmodule

// File: tb/tb_decomp_bit_aligner.sv
// tb_decomp_bit_aligner: directed bench comparing the aligner against a bit-queue stream model.
module tb_decomp_bit_aligner;
    import decomp_align_pkg::*;
    localparam int WIDTH = DEF_WIDTH;
    localparam int IN_W  = DEF_IN_W;
    localparam int OUT_W = DEF_OUT_W;
    localparam int LEN_W = $clog2(OUT_W + 1);

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        done, err;
    logic [31:0] stat_words, stat_bits;

    decomp_bit_aligner_if #(.WIDTH(WIDTH), .IN_W(IN_W), .OUT_W(OUT_W)) bus ();

    decomp_bit_aligner #(.WIDTH(WIDTH), .IN_W(IN_W), .OUT_W(OUT_W)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_flush      (flush),
        .bus          (bus),
        .o_done       (done),
        .o_err        (err),
        .o_stat_words (stat_words),
        .o_stat_bits  (stat_bits)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Model: the buffer is just the queue of not-yet-consumed stream bits, oldest first.
    bit          mq[$];
    int          m_state = 0;
    bit          m_done = 1'b0;
    int unsigned m_words = 0;
    int unsigned m_bits = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [OUT_W-1:0] m_peek();
        logic [OUT_W-1:0] p = '0;
        for (int i = 0; i < OUT_W; i++) p[OUT_W-1-i] = (i < mq.size()) ? mq[i] : 1'b0;
        return p;
    endfunction

    function automatic bit m_ready();
        return rst_n && m_state == 0 && mq.size() <= WIDTH - IN_W;
    endfunction

    task automatic m_clear();
        mq.delete();
        m_state = 0;
        m_done  = 1'b0;
        m_words = 0;
        m_bits  = 0;
    endtask

    task automatic m_step();
        bit rdy = m_ready();
        int len = int'(bus.i_take_len);
        m_done = 1'b0;
        if (flush) begin
            mq.delete();
            m_state = 0;
            return;
        end
        if (bus.i_take && m_state != 2 && (len > mq.size() || len > OUT_W)) begin
            m_state = 2;
            return;
        end
        if (bus.i_take && m_state != 2) begin
            repeat (len) void'(mq.pop_front());
            m_bits += len;
        end
        if (bus.i_in_valid && rdy) begin
            for (int i = IN_W - 1; i >= 0; i--) mq.push_back(bus.i_in_word[i]);
            m_words++;
            if (bus.i_in_last) m_state = 1;
        end
        if (m_state == 1 && mq.size() == 0) begin
            m_done  = 1'b1;
            m_state = 0;
        end
    endtask

    always @(negedge clk) begin
        chk("fill",  64'(bus.o_fill), 64'(mq.size()));
        chk("peek",  bus.o_peek, m_peek());
        chk("ready", bus.o_in_ready, m_ready());
        chk("err",   err, m_state == 2);
        chk("done",  done, m_done);
`ifdef DECOMP_ALIGN_STATS_EN
        chk("stat_words", stat_words, m_words);
        chk("stat_bits",  stat_bits,  m_bits);
`else
        chk("stat_words", stat_words, 0);
        chk("stat_bits",  stat_bits,  0);
`endif
    end

    task automatic cyc(input bit v, input logic [31:0] w, input bit l, input bit tk, input int tl, input bit fl);
        bus.i_in_valid = v;
        bus.i_in_word  = w;
        bus.i_in_last  = l;
        bus.i_take     = tk;
        bus.i_take_len = LEN_W'(tl);
        flush          = fl;
        @(posedge clk);
        m_step();
        @(negedge clk);
        bus.i_in_valid = 1'b0;
        bus.i_in_word  = '0;
        bus.i_in_last  = 1'b0;
        bus.i_take     = 1'b0;
        bus.i_take_len = '0;
        flush          = 1'b0;
    endtask

    task automatic push(input logic [31:0] w);
        cyc(1'b1, w, 1'b0, 1'b0, 0, 1'b0);
    endtask

    task automatic take(input int n);
        cyc(1'b0, 32'h0, 1'b0, 1'b1, n, 1'b0);
    endtask

    task automatic do_flush();
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 0, 1'b1);
    endtask

    initial begin
        bus.i_in_valid = 1'b0;
        bus.i_in_word  = '0;
        bus.i_in_last  = 1'b0;
        bus.i_take     = 1'b0;
        bus.i_take_len = '0;
        m_clear();
        repeat (2) @(negedge clk);
        chk("rst_ready", bus.o_in_ready, 0);
        chk("rst_fill",  64'(bus.o_fill), 0);
        chk("rst_peek",  bus.o_peek, 0);
        #1 rst_n = 1'b1;

        // single word lands at the top of the window
        push(32'hDEADBEEF);
        chk("push1_fill", 64'(bus.o_fill), 32);
        chk("push1_peek", bus.o_peek, 64'hDEADBEEF_00000000);

        push(32'h12345678);
        take(8);
        chk("take8_fill", 64'(bus.o_fill), 56);
        chk("take8_peek", bus.o_peek, 64'hADBEEF12_34567800);

        // simultaneous take and append
        do_flush();
        push(32'hDEADBEEF);
        push(32'h12345678);
        take(24);
        chk("fill40", 64'(bus.o_fill), 40);
        cyc(1'b1, 32'hCAFEF00D, 1'b0, 1'b1, 16, 1'b0);
        chk("tkapp_fill", 64'(bus.o_fill), 56);
        chk("tkapp_peek", bus.o_peek, 64'h345678CA_FEF00D00);

        // full boundary
        do_flush();
        for (int i = 0; i < 6; i++) push(32'h01010101 * (i + 1));
        chk("full_fill",  64'(bus.o_fill), 192);
        chk("full_ready", bus.o_in_ready, 0);
        cyc(1'b1, 32'hFFFFFFFF, 1'b0, 1'b1, 32, 1'b0);
        chk("room_fill",  64'(bus.o_fill), 160);
        chk("room_ready", bus.o_in_ready, 1);
        push(32'hA5A5A5A5);
        chk("refill", 64'(bus.o_fill), 192);

        // over-take, ignored takes in ERR, flush recovery
        do_flush();
        push(32'hF0F0F0F0);
        take(22);
        chk("fill10", 64'(bus.o_fill), 10);
        take(11);
        chk("over_err",   err, 1);
        chk("over_fill",  64'(bus.o_fill), 10);
        chk("over_ready", bus.o_in_ready, 0);
        take(4);
        chk("errtake_fill", 64'(bus.o_fill), 10);
        do_flush();
        chk("flush_err",  err, 0);
        chk("flush_fill", 64'(bus.o_fill), 0);

        // last word, drain to empty
        cyc(1'b1, 32'h0000FFFF, 1'b1, 1'b0, 0, 1'b0);
        chk("drain_ready", bus.o_in_ready, 0);
        chk("drain_peek",  bus.o_peek, 64'h0000FFFF_00000000);
        cyc(1'b1, 32'h11111111, 1'b0, 1'b1, 16, 1'b0);
        chk("drain_fill16", 64'(bus.o_fill), 16);
        chk("drain_nodone", done, 0);
        take(16);
        chk("done_pulse", done, 1);
        chk("done_fill",  64'(bus.o_fill), 0);
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 0, 1'b0);
        chk("done_clear", done, 0);
        chk("fill_again", bus.o_in_ready, 1);

        // empty boundary
        take(0);
        chk("take0_err", err, 0);
        take(1);
        chk("take1_err", err, 1);
        do_flush();

        // take longer than the window
        push(32'h11223344);
        push(32'h55667788);
        push(32'h99AABBCC);
        take(65);
        chk("len65_err",  err, 1);
        chk("len65_fill", 64'(bus.o_fill), 96);
        do_flush();

        // asynchronous reset mid-stream
        push(32'h89ABCDEF);
        push(32'h01234567);
        take(12);
        #2 rst_n = 1'b0;
        m_clear();
        #1;
        chk("arst_fill",  64'(bus.o_fill), 0);
        chk("arst_peek",  bus.o_peek, 0);
        chk("arst_ready", bus.o_in_ready, 0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        push(32'hCAFEBABE);
        chk("post_rst_peek", bus.o_peek, 64'hCAFEBABE_00000000);
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
